// File: rtl/fifo_wr_packer.sv
// ----------------------------------------------------------------------------
// fifo_wr_packer
//
// Write-side front end for the dual-clock FIFO, entirely in the write clock
// domain. Packs a stream of IN_WIDTH lanes (valid/ready, with a packet-end
// marker) into OUT_WIDTH words and pushes them into the FIFO write port,
// throttled by the FIFO full flag. A packet's short final word is padded
// with PAD_VALUE. Word, packet and padded-word counters plus a sticky
// overflow flag are kept for software.
//
// Ports:
//   wr_clk_i        write-domain clock, rising edge
//   rst_i           asynchronous, active-high reset
//   s_valid_i       input lane valid
//   s_data_i        input lane data (IN_WIDTH)
//   s_last_i        lane is the last of its packet (qualified by s_valid_i)
//   s_ready_o       block can accept a lane this cycle
//   fifo_full_i     FIFO full flag
//   fifo_wr_error_i FIFO write-error flag
//   fifo_wr_en_o    FIFO write enable
//   fifo_wdata_o    FIFO write data (OUT_WIDTH)
//   word_cnt_o      words written to the FIFO
//   pkt_cnt_o       packets completed
//   pad_cnt_o       words emitted with padding
//   overflow_o      sticky: FIFO reported a write error
// ----------------------------------------------------------------------------
module fifo_wr_packer #(
    parameter int unsigned          IN_WIDTH  = 8,
    parameter int unsigned          OUT_WIDTH = 16,
    parameter logic [IN_WIDTH-1:0]  PAD_VALUE = '0,
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  logic                  wr_clk_i,
    input  logic                  rst_i,
    input  logic                  s_valid_i,
    input  logic [IN_WIDTH-1:0]   s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    input  logic                  fifo_full_i,
    input  logic                  fifo_wr_error_i,
    output logic                  fifo_wr_en_o,
    output logic [OUT_WIDTH-1:0]  fifo_wdata_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [CNT_WIDTH-1:0]  pad_cnt_o,
    output logic                  overflow_o
);

    localparam int unsigned LANES = OUT_WIDTH / IN_WIDTH;
    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    generate
        if ((OUT_WIDTH % IN_WIDTH) != 0 || LANES < 2) begin : g_bad_params
            $error("fifo_wr_packer: OUT_WIDTH must be a multiple of IN_WIDTH with at least 2 lanes");
        end
    endgenerate

    // State
    logic [IDX_W-1:0]                idx_q,   idx_d;
    logic [LANES-1:0][IN_WIDTH-1:0]  asm_q,   asm_d;
    logic [OUT_WIDTH-1:0]            out_q,   out_d;
    logic                            pend_q,  pend_d;
    logic [CNT_WIDTH-1:0]            word_q,  word_d;
    logic [CNT_WIDTH-1:0]            pkt_q,   pkt_d;
    logic [CNT_WIDTH-1:0]            pad_q,   pad_d;
    logic                            ovf_q,   ovf_d;

    logic                            push;
    logic                            accept;
    logic                            completing;
    logic [LANES-1:0][IN_WIDTH-1:0]  merged;

    // The hold stage drains on the same edge a new lane is taken, so a full
    // FIFO only stalls the input once a finished word is actually waiting.
    assign push       = pend_q & ~fifo_full_i;
    assign s_ready_o  = ~pend_q | ~fifo_full_i;
    assign accept     = s_valid_i & s_ready_o;
    assign completing = (idx_q == LAST_IDX) | s_last_i;

    // NOTE: every variable assigned in always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        // Current lane merged at idx; lanes above it padded on packet end.
        merged = asm_q;
        for (int i = 0; i < LANES; i++) begin
            if (IDX_W'(i) == idx_q) begin
                merged[i] = s_data_i;
            end else if (IDX_W'(i) > idx_q && s_last_i) begin
                merged[i] = PAD_VALUE;
            end
        end

        idx_d  = idx_q;
        asm_d  = asm_q;
        out_d  = out_q;
        pend_d = pend_q & ~push;
        word_d = word_q;
        pkt_d  = pkt_q;
        pad_d  = pad_q;
        ovf_d  = ovf_q | fifo_wr_error_i;

        if (accept) begin
            if (completing) begin
                // Overrides the push-clear above: back-to-back words.
                out_d  = merged;
                pend_d = 1'b1;
                idx_d  = '0;
                asm_d  = '0;
                if (s_last_i) begin
                    pkt_d = pkt_q + CNT_WIDTH'(1);
                    if (idx_q != LAST_IDX) begin
                        pad_d = pad_q + CNT_WIDTH'(1);
                    end
                end
            end else begin
                asm_d[idx_q] = s_data_i;
                idx_d        = idx_q + 1'b1;
            end
        end

        if (push) begin
            word_d = word_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge wr_clk_i or posedge rst_i) begin
        if (rst_i) begin
            idx_q  <= '0;
            asm_q  <= '0;
            out_q  <= '0;
            pend_q <= 1'b0;
            word_q <= '0;
            pkt_q  <= '0;
            pad_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            asm_q  <= asm_d;
            out_q  <= out_d;
            pend_q <= pend_d;
            word_q <= word_d;
            pkt_q  <= pkt_d;
            pad_q  <= pad_d;
            ovf_q  <= ovf_d;
        end
    end

    assign fifo_wr_en_o = push;
    assign fifo_wdata_o = out_q;
    assign word_cnt_o   = word_q;
    assign pkt_cnt_o    = pkt_q;
    assign pad_cnt_o    = pad_q;
    assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_fifo_wr_packer.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_packer
//
// Directed testbench for fifo_wr_packer (IN_WIDTH=8, OUT_WIDTH=16, PAD=0).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A falling-edge monitor records every FIFO write with
// its cycle number so word order and spacing can be checked.
// ----------------------------------------------------------------------------
module tb_fifo_wr_packer;

    logic        wr_clk_i = 1'b0;
    logic        rst_i;
    logic        s_valid_i;
    logic [7:0]  s_data_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic        fifo_full_i;
    logic        fifo_wr_error_i;
    logic        fifo_wr_en_o;
    logic [15:0] fifo_wdata_o;
    logic [15:0] word_cnt_o;
    logic [15:0] pkt_cnt_o;
    logic [15:0] pad_cnt_o;
    logic        overflow_o;

    fifo_wr_packer #(
        .IN_WIDTH  (8),
        .OUT_WIDTH (16),
        .PAD_VALUE (8'h00),
        .CNT_WIDTH (16)
    ) dut (
        .wr_clk_i        (wr_clk_i),
        .rst_i           (rst_i),
        .s_valid_i       (s_valid_i),
        .s_data_i        (s_data_i),
        .s_last_i        (s_last_i),
        .s_ready_o       (s_ready_o),
        .fifo_full_i     (fifo_full_i),
        .fifo_wr_error_i (fifo_wr_error_i),
        .fifo_wr_en_o    (fifo_wr_en_o),
        .fifo_wdata_o    (fifo_wdata_o),
        .word_cnt_o      (word_cnt_o),
        .pkt_cnt_o       (pkt_cnt_o),
        .pad_cnt_o       (pad_cnt_o),
        .overflow_o      (overflow_o)
    );

    always #5 wr_clk_i = ~wr_clk_i;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          stall_cnt = 0;
    int          full_viol = 0;
    logic [15:0] wq[$];
    int          wc[$];

    always @(posedge wr_clk_i) cyc <= cyc + 1;

    // Record writes the FIFO will take on the coming rising edge.
    always @(negedge wr_clk_i) begin
        if (!rst_i && fifo_wr_en_o) begin
            wq.push_back(fifo_wdata_o);
            wc.push_back(cyc);
        end
        if (fifo_wr_en_o && fifo_full_i) full_viol++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // All tasks below start and end at 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge wr_clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        @(posedge wr_clk_i);
        #1;
        rst_i = 1'b0;
        wq.delete();
        wc.delete();
    endtask

    // Present one lane and wait (bounded) until it is accepted.
    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = l;
        @(negedge wr_clk_i);
        while (!s_ready_o && n < 50) begin
            @(negedge wr_clk_i);
            n++;
        end
        stall_cnt += n;
        if (n >= 50) check("send_timeout", 32'(n), 32'd0);
        @(posedge wr_clk_i);
        #1;
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        s_valid_i = 1'b0;
        s_data_i = '0;
        s_last_i = 1'b0;
        fifo_full_i = 1'b0;
        fifo_wr_error_i = 1'b0;

        // Reset state
        #2;
        check("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        check("rst_ready", 32'(s_ready_o), 32'd1);
        check("rst_word_cnt", 32'(word_cnt_o), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt_o), 32'd0);
        check("rst_pad_cnt", 32'(pad_cnt_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        repeat (2) @(posedge wr_clk_i);
        #1;
        rst_i = 1'b0;
        idle(10);
        check("idle_no_writes", 32'(wq.size()), 32'd0);

        // Two lanes -> one word, with an idle gap between lanes
        do_reset();
        send(8'h11, 1'b0);
        idle(3);
        send(8'h22, 1'b0);
        @(negedge wr_clk_i);
        check("pair_wr_en", 32'(fifo_wr_en_o), 32'd1);
        check("pair_wdata", 32'(fifo_wdata_o), 32'h2211);
        @(negedge wr_clk_i);
        check("pair_wr_en_drop", 32'(fifo_wr_en_o), 32'd0);
        @(posedge wr_clk_i);
        #1;
        idle(2);
        check("pair_nwrites", 32'(wq.size()), 32'd1);
        check("pair_word", 32'(wq[0]), 32'h2211);
        check("pair_word_cnt", 32'(word_cnt_o), 32'd1);

        // Packet AA BB CC(last), then last on lane 0, then last on lane 1
        do_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b1);
        idle(4);
        check("pkt_nwrites", 32'(wq.size()), 32'd2);
        check("pkt_word0", 32'(wq[0]), 32'hBBAA);
        check("pkt_word1", 32'(wq[1]), 32'h00CC);
        check("pkt_pkt_cnt", 32'(pkt_cnt_o), 32'd1);
        check("pkt_pad_cnt", 32'(pad_cnt_o), 32'd1);
        check("pkt_word_cnt", 32'(word_cnt_o), 32'd2);
        send(8'hEE, 1'b1);
        idle(3);
        check("last0_word", 32'(wq[2]), 32'h00EE);
        check("last0_pad_cnt", 32'(pad_cnt_o), 32'd2);
        check("last0_pkt_cnt", 32'(pkt_cnt_o), 32'd2);
        send(8'h12, 1'b0);
        send(8'h34, 1'b1);
        idle(3);
        check("last1_word", 32'(wq[3]), 32'h3412);
        check("last1_pad_cnt", 32'(pad_cnt_o), 32'd2);
        check("last1_pkt_cnt", 32'(pkt_cnt_o), 32'd3);
        check("last1_word_cnt", 32'(word_cnt_o), 32'd4);

        // Backpressure: FIFO full, word 0201 held, ready drops
        do_reset();
        fifo_full_i = 1'b1;
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        s_valid_i = 1'b1;
        s_data_i  = 8'h03;
        for (int k = 0; k < 3; k++) begin
            @(negedge wr_clk_i);
            check("full_ready", 32'(s_ready_o), 32'd0);
            check("full_wr_en", 32'(fifo_wr_en_o), 32'd0);
            check("full_wdata_hold", 32'(fifo_wdata_o), 32'h0201);
        end
        @(posedge wr_clk_i);
        #1;
        check("full_no_writes", 32'(wq.size()), 32'd0);
        fifo_full_i = 1'b0;
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        idle(4);
        check("full_nwrites", 32'(wq.size()), 32'd2);
        check("full_word0", 32'(wq[0]), 32'h0201);
        check("full_word1", 32'(wq[1]), 32'h0403);
        check("full_word_cnt", 32'(word_cnt_o), 32'd2);

        // Continuous stream 00..07
        do_reset();
        stall_cnt = 0;
        for (int i = 0; i < 8; i++) send(8'(i), 1'b0);
        idle(4);
        check("stream_stalls", 32'(stall_cnt), 32'd0);
        check("stream_nwrites", 32'(wq.size()), 32'd4);
        check("stream_w0", 32'(wq[0]), 32'h0100);
        check("stream_w1", 32'(wq[1]), 32'h0302);
        check("stream_w2", 32'(wq[2]), 32'h0504);
        check("stream_w3", 32'(wq[3]), 32'h0706);
        for (int k = 0; k < 3; k++) begin
            if (wc.size() == 4) check("stream_spacing", 32'(wc[k+1] - wc[k]), 32'd2);
        end

        // Reset mid-word discards the partial lane
        do_reset();
        send(8'h55, 1'b0);
        rst_i = 1'b1;
        @(posedge wr_clk_i);
        #1;
        rst_i = 1'b0;
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        idle(3);
        check("rst_mid_nwrites", 32'(wq.size()), 32'd1);
        check("rst_mid_word", 32'(wq[0]), 32'h7766);
        check("rst_mid_word_cnt", 32'(word_cnt_o), 32'd1);
        // Reset with a pending word drops wr_en at once
        send(8'h88, 1'b0);
        send(8'h99, 1'b0);
        check("rst_pend_wr_en", 32'(fifo_wr_en_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check("rst_pend_drop", 32'(fifo_wr_en_o), 32'd0);
        @(posedge wr_clk_i);
        #1;
        rst_i = 1'b0;
        idle(3);
        check("rst_pend_nwrites", 32'(wq.size()), 32'd1);
        check("rst_pend_word_cnt", 32'(word_cnt_o), 32'd0);

        // Sticky overflow
        fifo_wr_error_i = 1'b1;
        @(posedge wr_clk_i);
        #1;
        fifo_wr_error_i = 1'b0;
        check("ovf_set", 32'(overflow_o), 32'd1);
        idle(5);
        check("ovf_sticky", 32'(overflow_o), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(overflow_o), 32'd0);

        check("never_write_when_full", 32'(full_viol), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
